// File: rtl/msbs_t3_seq_ctrl_pkg.sv
// Shared FSM encodings and control-bus bit positions for the t=3 mSBS sequencer and its datapath.
// Keeping the bus indices here keeps the controller and the buffer packing in step.
package msbs_t3_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLR     = 2'd1,
        ST_COLLECT = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_SH_EN     = 1;
    localparam int CTRL_PASS_LAST = 2;
    localparam int CTRL_CLR       = 3;
    localparam int CTRL_W         = 4;

endpackage

// File: rtl/msbs_t3_seq_ctrl.sv
// Sequencer for the t=3 sequential mSBS datapath: one syndrome triple per Chase pattern, then hold the filled bank.
// Latency: last pattern accepted at edge E -> out_coef_valid from E; out_synd_ready is low outside COLLECT and in HOLD.
// Backpressure: the bank is held with out_coef_valid until in_coef_ready; enables are combinational from in_synd_valid.
module msbs_t3_seq_ctrl
    import msbs_t3_seq_ctrl_pkg::*;
#(
    parameter int TEST_PATTEN_NUMS = 8,
    parameter int CNT_WIDTH        = 3,
    parameter int PASSING_LAST_EN  = 0
) (
    input  logic                 clk,
    input  logic                 in_ctr_Srst,
    input  logic                 in_start,
    input  logic                 in_abort,
    input  logic                 in_synd_valid,
    output logic                 out_synd_ready,
    output logic                 out_msbs_clr,
    output logic                 out_msbs_en,
    output logic                 out_msbs_sh_en,
    output logic                 out_msbs_pass_last,
    output logic [CNT_WIDTH-1:0] out_tp_idx,
    output logic                 out_coef_valid,
    input  logic                 in_coef_ready,
    output logic                 out_busy,
    output logic                 out_err_start
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(TEST_PATTEN_NUMS - 1);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_err_start;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_abort;
    logic                  w_err;
    logic                  w_ready;
    logic                  w_coef_valid;
    logic [CTRL_W-1:0]     w_ctrl;

    assign w_abort = in_abort & (r_state != ST_IDLE);
    assign w_xfer  = in_synd_valid & (r_state == ST_COLLECT);
    assign w_last  = (r_count == LAST_IDX);
    // A start is only legal from IDLE or as a HOLD hand-off; everything else is flagged.
    assign w_err   = in_start & (r_state != ST_IDLE) & ~((r_state == ST_HOLD) & in_coef_ready);

    always_ff @(posedge clk) begin
        if (!in_ctr_Srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (in_start) w_next = ST_CLR;
            ST_CLR:     w_next = ST_COLLECT;
            ST_COLLECT: if (w_xfer && w_last) w_next = ST_HOLD;
            ST_HOLD:    if (in_coef_ready) w_next = in_start ? ST_CLR : ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        if (w_abort) w_next = ST_IDLE;
    end

    always_comb begin
        w_ctrl       = '0;
        w_ready      = 1'b0;
        w_coef_valid = 1'b0;
        case (r_state)
            ST_CLR: begin
                w_ctrl[CTRL_CLR] = 1'b1;
                w_ctrl[CTRL_EN]  = 1'b1;
            end
            ST_COLLECT: begin
                w_ready                = 1'b1;
                w_ctrl[CTRL_EN]        = w_xfer;
                w_ctrl[CTRL_SH_EN]     = w_xfer;
                w_ctrl[CTRL_PASS_LAST] = w_xfer & w_last & (PASSING_LAST_EN != 0);
            end
            ST_HOLD:  w_coef_valid = 1'b1;
            default:  w_ctrl = '0;
        endcase
    end

    // Count resets whenever we leave or are not in COLLECT, so tp_idx reads 0 in IDLE/CLR/HOLD.
    always_ff @(posedge clk) begin
        if (!in_ctr_Srst) begin
            r_count     <= '0;
            r_err_start <= 1'b0;
        end else begin
            r_err_start <= w_err;
            if (w_abort || (r_state != ST_COLLECT)) begin
                r_count <= '0;
            end else if (w_xfer) begin
                r_count <= w_last ? '0 : r_count + 1'b1;
            end
        end
    end

    assign out_synd_ready     = w_ready;
    assign out_msbs_clr       = w_ctrl[CTRL_CLR];
    assign out_msbs_en        = w_ctrl[CTRL_EN];
    assign out_msbs_sh_en     = w_ctrl[CTRL_SH_EN];
    assign out_msbs_pass_last = w_ctrl[CTRL_PASS_LAST];
    assign out_tp_idx         = r_count;
    assign out_coef_valid     = w_coef_valid;
    assign out_busy           = (r_state != ST_IDLE);
    assign out_err_start      = r_err_start;

endmodule

// File: tb/tb_msbs_t3_seq_ctrl.sv
// Bench for msbs_t3_seq_ctrl: timing table plus scoreboarded frames against a behavioural shift buffer.
module tb_msbs_t3_seq_ctrl;

    localparam int N = 8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       srst_n, start, abort, valid, coef_ready;
    logic [7:0] synd;

    logic       ready, clr, en, sh_en, pass_last, coef_valid, busy, err_start;
    logic [2:0] tp_idx;
    logic       ready_0, clr_0, en_0, sh_en_0, pass_last_0, coef_valid_0, busy_0, err_start_0;
    logic [2:0] tp_idx_0;

    msbs_t3_seq_ctrl #(.TEST_PATTEN_NUMS(N), .CNT_WIDTH(3), .PASSING_LAST_EN(1)) u_dut (
        .clk(clk), .in_ctr_Srst(srst_n), .in_start(start), .in_abort(abort),
        .in_synd_valid(valid), .out_synd_ready(ready), .out_msbs_clr(clr),
        .out_msbs_en(en), .out_msbs_sh_en(sh_en), .out_msbs_pass_last(pass_last),
        .out_tp_idx(tp_idx), .out_coef_valid(coef_valid), .in_coef_ready(coef_ready),
        .out_busy(busy), .out_err_start(err_start)
    );

    msbs_t3_seq_ctrl #(.TEST_PATTEN_NUMS(N), .CNT_WIDTH(3), .PASSING_LAST_EN(0)) u_dut0 (
        .clk(clk), .in_ctr_Srst(srst_n), .in_start(start), .in_abort(abort),
        .in_synd_valid(valid), .out_synd_ready(ready_0), .out_msbs_clr(clr_0),
        .out_msbs_en(en_0), .out_msbs_sh_en(sh_en_0), .out_msbs_pass_last(pass_last_0),
        .out_tp_idx(tp_idx_0), .out_coef_valid(coef_valid_0), .in_coef_ready(coef_ready),
        .out_busy(busy_0), .out_err_start(err_start_0)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] bank [N];
    logic [7:0] q [$];

    function automatic logic [7:0] coef_of(input logic [7:0] s);
        return {s[3:0], s[7:4]} ^ 8'h3C;
    endfunction

    // Behavioural sequential-to-simultaneous buffer steered only by the DUT controls.
    always @(posedge clk) begin
        if (en) begin
            if (clr) begin
                for (int i = 0; i < N; i++) bank[i] <= 8'h00;
            end else if (sh_en) begin
                for (int i = N - 1; i > 0; i--) bank[i] <= bank[i-1];
                bank[0] <= coef_of(synd);
            end
        end
    end

    typedef struct {
        logic        start, valid, abort, cready;
        logic [10:0] exp;
    } vec_t;
    vec_t tbl [13];

    function automatic vec_t mk(input logic st, v, ab, cr, input logic [10:0] e);
        vec_t r;
        r.start = st; r.valid = v; r.abort = ab; r.cready = cr; r.exp = e;
        return r;
    endfunction

    // {ready, clr, en, sh_en, pass_last, coef_valid, busy, err_start, tp_idx}
    function automatic logic [10:0] get_out();
        return {ready, clr, en, sh_en, pass_last, coef_valid, busy, err_start, tp_idx};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 0; abort = 0; valid = 0; coef_ready = 0;
    endtask

    task automatic check_bank(input string tag);
        logic [7:0] e;
        chk({tag, "_qsize"}, q.size(), N);
        for (int i = 0; i < N && q.size() > 0; i++) begin
            e = q.pop_front();
            chk($sformatf("%s_bank%0d", tag, N - 1 - i), bank[N-1-i], e);
        end
        q.delete();
    endtask

    task automatic begin_frame(input string tag);
        start = 1; valid = 0;
        tick();
        start = 0;
        #2;
        chk({tag, "_clr"}, clr, 1);
        chk({tag, "_clr_en"}, en, 1);
        tick();
    endtask

    task automatic do_xfers(input string tag, input int bubble, input int start_at, input int abort_at);
        int   k;
        logic v, prev_st;
        k = 0; prev_st = 0;
        for (int cyc = 0; cyc < 64 && k < N; cyc++) begin
            v     = bubble ? (cyc % 3 == 0) : 1'b1;
            synd  = 8'($urandom);
            valid = v;
            start = v && (k == start_at);
            abort = v && (k == abort_at);
            #2;
            chk($sformatf("%s_en_c%0d", tag, cyc), en, v);
            chk($sformatf("%s_shen_c%0d", tag, cyc), sh_en, v);
            chk($sformatf("%s_rdy_c%0d", tag, cyc), ready, 1);
            chk($sformatf("%s_idx_c%0d", tag, cyc), tp_idx, k);
            chk($sformatf("%s_err_c%0d", tag, cyc), err_start, prev_st);
            if (v) begin
                chk($sformatf("%s_pl_k%0d", tag, k), pass_last, (k == N - 1));
                chk($sformatf("%s_pl0_k%0d", tag, k), pass_last_0, 0);
                q.push_back(coef_of(synd));
            end
            prev_st = start;
            if (v) k++;
            if (abort) begin
                tick();
                idle_in();
                q.delete();
                return;
            end
            tick();
        end
        idle_in();
        if (k < N) chk({tag, "_xfer_timeout"}, k, N);
    endtask

    task automatic finish_hold(input string tag, input logic restart);
        valid = 1;
        #2;
        chk({tag, "_hold_cv"}, coef_valid, 1);
        chk({tag, "_hold_rdy"}, ready, 0);
        chk({tag, "_hold_en"}, en, 0);
        chk({tag, "_hold_idx"}, tp_idx, 0);
        check_bank(tag);
        coef_ready = 1; start = restart; valid = 0;
        tick();
        idle_in();
        #2;
        chk({tag, "_after_cv"}, coef_valid, 0);
        chk({tag, "_after_clr"}, clr, restart);
        chk({tag, "_after_busy"}, busy, restart);
        chk({tag, "_after_err"}, err_start, 0);
    endtask

    logic [7:0] snap [N];
    int         same;

    initial begin
        idle_in();
        synd   = 8'h00;
        srst_n = 0;
        tick(); tick();
        srst_n = 1;
        valid  = 1;
        #2;
        chk("reset_outputs", get_out(), 0);
        valid = 0;

        // Nominal timing table: IDLE, CLR, 8 xfers, two HOLD cycles, then IDLE abort no-op.
        tbl[0]  = mk(1, 1, 0, 0, 11'b0_0_0_0_0_0_0_0_000);
        tbl[1]  = mk(0, 1, 0, 0, 11'b0_1_1_0_0_0_1_0_000);
        for (int k = 0; k < N; k++)
            tbl[2+k] = mk(0, 1, 0, 0, {1'b1, 1'b0, 1'b1, 1'b1, (k == N - 1), 1'b0, 1'b1, 1'b0, 3'(k)});
        tbl[10] = mk(0, 1, 0, 0, 11'b0_0_0_0_0_1_1_0_000);
        tbl[11] = mk(0, 1, 0, 1, 11'b0_0_0_0_0_1_1_0_000);
        tbl[12] = mk(0, 0, 1, 0, 11'b0_0_0_0_0_0_0_0_000);
        for (int r = 0; r < 13; r++) begin
            start = tbl[r].start; valid = tbl[r].valid;
            abort = tbl[r].abort; coef_ready = tbl[r].cready;
            synd  = 8'(r);
            #2;
            chk($sformatf("row%0d", r), get_out(), tbl[r].exp);
            tick();
        end
        idle_in();
        #2;
        chk("idle_after_abort_noop", busy, 0);

        // Nominal frame with scoreboarded bank.
        begin_frame("nom");
        do_xfers("nom", 0, -1, -1);
        finish_hold("nom", 0);

        // Reset mid-COLLECT at count 5.
        begin_frame("rst");
        for (int k = 0; k < 5; k++) begin
            valid = 1; synd = 8'(k);
            tick();
        end
        #2;
        chk("rst_idx_before", tp_idx, 5);
        srst_n = 0;
        tick();
        srst_n = 1;
        #2;
        chk("rst_outputs", get_out(), 0);
        idle_in();
        q.delete();

        // Valid bubbles.
        begin_frame("bub");
        do_xfers("bub", 1, -1, -1);
        finish_hold("bub", 0);

        // Back-pressure in HOLD, then hand-off straight into a new frame.
        begin_frame("bp");
        do_xfers("bp", 0, -1, -1);
        for (int i = 0; i < N; i++) snap[i] = bank[i];
        for (int c = 0; c < 20; c++) begin
            valid = 1; coef_ready = 0;
            #2;
            same = 1;
            for (int i = 0; i < N; i++) if (bank[i] !== snap[i]) same = 0;
            chk($sformatf("bp_cv_c%0d", c), coef_valid, 1);
            chk($sformatf("bp_rdy_c%0d", c), ready, 0);
            chk($sformatf("bp_stable_c%0d", c), same, 1);
            tick();
        end
        valid = 0;
        check_bank("bp");
        coef_ready = 1; start = 1;
        tick();
        idle_in();
        #2;
        chk("bp_b2b_clr", clr, 1);
        chk("bp_b2b_err", err_start, 0);
        tick();
        do_xfers("bp2", 0, -1, -1);
        finish_hold("bp2", 0);

        // Abort on the final transfer.
        begin_frame("ab");
        do_xfers("ab", 0, -1, N - 1);
        #2;
        chk("ab_busy", busy, 0);
        chk("ab_cv", coef_valid, 0);
        tick();
        #2;
        chk("ab_cv_later", coef_valid, 0);
        begin_frame("ab2");
        do_xfers("ab2", 0, -1, -1);
        finish_hold("ab2", 0);

        // Start during COLLECT flags an error without disturbing the frame.
        begin_frame("es");
        do_xfers("es", 0, 3, -1);
        finish_hold("es", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
